player_motion_ctrl: RTL and testbench

Per-frame player motion stage that sits directly upstream of the colour mapper and drives its `playerX`, `playerY`, facing and animation-frame inputs. On each rising edge of `frame_clk` it samples the keyboard keycode and computes a candidate position. It checks the four corners of the player's bounding box against the 20×20 tile map and commits the move only if no corner lands on a wall tile. A fixed-latency FSM does all of this in the `Clk` domain and produces a one-cycle `update_done` strobe.

---
 rtl/player_motion_ctrl.sv | 149 ++++++++++++++
 tb/tb_player_motion_ctrl.sv | 306 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/player_motion_ctrl.sv
// Per-frame player motion: samples the keycode on a frame tick, clamps a candidate
// position to the playfield and commits it only if no bounding-box corner hits a wall.
//
// state   | meaning
// IDLE    | waiting for a frame tick (pending start is consumed here)
// CALC    | candidate position from latched key, clear blocked flag
// CHK0..3 | one bounding-box corner tested against the tile map per cycle
// COMMIT  | outputs, facing and animation update; update_done strobes
module player_motion_ctrl #(
    parameter logic [9:0] STEP     = 10'd2,
    parameter logic [9:0] PLAYER_W = 10'd13,
    parameter logic [9:0] PLAYER_H = 10'd16,
    parameter logic [9:0] START_X  = 10'd32,
    parameter logic [9:0] START_Y  = 10'd32,
    parameter logic [3:0] ANIM_DIV = 4'd8
) (
    input  logic              Clk,
    input  logic              reset,
    input  logic              frame_clk,
    input  logic [7:0]        keycode,
    input  logic [0:399][4:0] inMapData,
    output logic [9:0]        playerX,
    output logic [9:0]        playerY,
    output logic              left,
    output logic [1:0]        anim_frame,
    output logic              moving,
    output logic              update_done
);

    localparam logic [2:0] S_IDLE   = 3'd0;
    localparam logic [2:0] S_CALC   = 3'd1;
    localparam logic [2:0] S_CHK0   = 3'd2;
    localparam logic [2:0] S_CHK1   = 3'd3;
    localparam logic [2:0] S_CHK2   = 3'd4;
    localparam logic [2:0] S_CHK3   = 3'd5;
    localparam logic [2:0] S_COMMIT = 3'd6;

    localparam logic [7:0] KEY_LEFT  = 8'h04;
    localparam logic [7:0] KEY_RIGHT = 8'h07;
    localparam logic [7:0] KEY_UP    = 8'h1A;
    localparam logic [7:0] KEY_DOWN  = 8'h16;

    localparam logic [9:0] X_MAX = 10'd319 - PLAYER_W;
    localparam logic [9:0] Y_MAX = 10'd319 - PLAYER_H;

    logic [2:0] state;
    logic       frame_q;
    logic       rise;
    logic       start;
    logic [7:0] key_l;
    logic [9:0] nx, ny;
    logic       blk;
    logic [3:0] frame_cnt;

    logic [9:0] cand_x, cand_y;
    logic [9:0] cx, cy;
    logic [9:0] tile_idx;
    logic [4:0] tile;
    logic       corner_blk;
    logic       is_move;

    assign rise = frame_clk & ~frame_q;

    always_comb begin
        cand_x = playerX;
        cand_y = playerY;
        case (key_l)
            KEY_LEFT:  cand_x = (playerX < STEP) ? 10'd0 : playerX - STEP;
            KEY_RIGHT: cand_x = (playerX + STEP > X_MAX) ? X_MAX : playerX + STEP;
            KEY_UP:    cand_y = (playerY < STEP) ? 10'd0 : playerY - STEP;
            KEY_DOWN:  cand_y = (playerY + STEP > Y_MAX) ? Y_MAX : playerY + STEP;
            default:   ;
        endcase
    end

    // Corner under test is selected by the current CHK state.
    always_comb begin
        cx = nx;
        cy = ny;
        if (state == S_CHK1 || state == S_CHK3) cx = nx + PLAYER_W;
        if (state == S_CHK2 || state == S_CHK3) cy = ny + PLAYER_H;
        tile_idx   = (cy >> 4) * 10'd20 + (cx >> 4);
        tile       = (tile_idx < 10'd400) ? inMapData[tile_idx[8:0]] : 5'd0;
        corner_blk = (tile == 5'd1) || (tile == 5'd5) || (tile == 5'd6);
    end

    assign is_move = (key_l == KEY_LEFT) || (key_l == KEY_RIGHT) ||
                     (key_l == KEY_UP)   || (key_l == KEY_DOWN);

    always_ff @(posedge Clk) begin
        if (reset) begin
            state       <= S_IDLE;
            frame_q     <= 1'b0;
            start       <= 1'b0;
            key_l       <= 8'd0;
            nx          <= START_X;
            ny          <= START_Y;
            blk         <= 1'b0;
            frame_cnt   <= 4'd0;
            playerX     <= START_X;
            playerY     <= START_Y;
            left        <= 1'b0;
            anim_frame  <= 2'd0;
            moving      <= 1'b0;
            update_done <= 1'b0;
        end else begin
            frame_q     <= frame_clk;
            update_done <= 1'b0;
            start       <= 1'b0;
            // Ticks arriving while an update is in flight are dropped.
            if (rise && state == S_IDLE && !start) begin
                key_l <= keycode;
                start <= 1'b1;
            end
            case (state)
                S_IDLE: if (start) state <= S_CALC;
                S_CALC: begin
                    nx    <= cand_x;
                    ny    <= cand_y;
                    blk   <= 1'b0;
                    state <= S_CHK0;
                end
                S_CHK0: begin blk <= blk | corner_blk; state <= S_CHK1;   end
                S_CHK1: begin blk <= blk | corner_blk; state <= S_CHK2;   end
                S_CHK2: begin blk <= blk | corner_blk; state <= S_CHK3;   end
                S_CHK3: begin blk <= blk | corner_blk; state <= S_COMMIT; end
                S_COMMIT: begin
                    if (!blk) begin
                        playerX <= nx;
                        playerY <= ny;
                    end
                    if (key_l == KEY_LEFT)       left <= 1'b1;
                    else if (key_l == KEY_RIGHT) left <= 1'b0;
                    moving <= is_move;
                    if (frame_cnt == ANIM_DIV - 4'd1) begin
                        frame_cnt  <= 4'd0;
                        anim_frame <= anim_frame + 2'd1;
                    end else begin
                        frame_cnt <= frame_cnt + 4'd1;
                    end
                    update_done <= 1'b1;
                    state       <= S_IDLE;
                end
                default: state <= S_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_player_motion_ctrl.sv
// Self-checking bench for player_motion_ctrl: a behavioural model pushes expected
// outputs per accepted frame tick; they are popped when update_done strobes.
module tb_player_motion_ctrl;

    logic              Clk = 1'b0;
    logic              reset = 1'b1;
    logic              frame_clk = 1'b0;
    logic [7:0]        keycode = 8'd0;
    logic [0:399][4:0] map_bus = '0;
    logic [9:0]        playerX, playerY;
    logic              left, moving, update_done;
    logic [1:0]        anim_frame;

    player_motion_ctrl dut (
        .Clk(Clk), .reset(reset), .frame_clk(frame_clk), .keycode(keycode),
        .inMapData(map_bus), .playerX(playerX), .playerY(playerY), .left(left),
        .anim_frame(anim_frame), .moving(moving), .update_done(update_done)
    );

    always #5 Clk = ~Clk;

    typedef struct {
        logic [9:0] x;
        logic [9:0] y;
        logic       left;
        logic [1:0] anim;
        logic       moving;
    } exp_t;

    exp_t sb[$];
    int n_cmp = 0;
    int n_err = 0;

    logic [4:0] tmap [20][20];
    int  m_x, m_y, m_fc;
    logic m_left, m_moving;
    logic [1:0] m_anim;

    task automatic set_tile(input int r, input int c, input logic [4:0] v);
        tmap[r][c] = v;
        map_bus[r*20 + c] = v;
    endtask

    function automatic bit is_wall(input int x, input int y);
        logic [4:0] v;
        v = tmap[y/16][x/16];
        return (v == 5'd1) || (v == 5'd5) || (v == 5'd6);
    endfunction

    function automatic exp_t model_step(input logic [7:0] key);
        int nx, ny;
        bit b;
        exp_t r;
        nx = m_x;
        ny = m_y;
        case (key)
            8'h04: nx = (m_x < 2) ? 0 : m_x - 2;
            8'h07: nx = (m_x + 2 > 306) ? 306 : m_x + 2;
            8'h1A: ny = (m_y < 2) ? 0 : m_y - 2;
            8'h16: ny = (m_y + 2 > 303) ? 303 : m_y + 2;
            default: ;
        endcase
        b = is_wall(nx, ny) || is_wall(nx + 13, ny) ||
            is_wall(nx, ny + 16) || is_wall(nx + 13, ny + 16);
        if (!b) begin
            m_x = nx;
            m_y = ny;
        end
        if (key == 8'h04) m_left = 1'b1;
        else if (key == 8'h07) m_left = 1'b0;
        m_moving = (key == 8'h04) || (key == 8'h07) || (key == 8'h1A) || (key == 8'h16);
        if (m_fc == 7) begin
            m_fc = 0;
            m_anim = m_anim + 2'd1;
        end else begin
            m_fc = m_fc + 1;
        end
        r.x = 10'(m_x); r.y = 10'(m_y); r.left = m_left; r.anim = m_anim; r.moving = m_moving;
        return r;
    endfunction

    task automatic model_reset();
        m_x = 32; m_y = 32; m_fc = 0; m_left = 1'b0; m_moving = 1'b0; m_anim = 2'd0;
        sb.delete();
    endtask

    task automatic apply_reset();
        @(negedge Clk);
        reset = 1'b1;
        frame_clk = 1'b0;
        repeat (2) @(negedge Clk);
        reset = 1'b0;
        model_reset();
    endtask

    // One frame tick with the given key; checks 7-edge latency, outputs and strobe width.
    task automatic do_update(input logic [7:0] key, input string name);
        exp_t e;
        int n;
        bit seen;
        @(negedge Clk);
        keycode = key;
        frame_clk = 1'b1;
        sb.push_back(model_step(key));
        @(posedge Clk);
        @(negedge Clk);
        frame_clk = 1'b0;
        seen = 0;
        n = 0;
        while (!seen && n < 20) begin
            @(posedge Clk); n++; #1;
            if (update_done) seen = 1;
        end
        e = sb.pop_front();
        n_cmp++;
        if (!seen) begin
            n_err++;
            $display("FAIL %s: timeout, update_done not seen within 20 edges", name);
        end else begin
            if (n != 7) begin
                n_err++;
                $display("FAIL %s latency: got %0d edges, expected 7", name, n);
            end
            n_cmp++;
            if (playerX !== e.x || playerY !== e.y || left !== e.left ||
                anim_frame !== e.anim || moving !== e.moving) begin
                n_err++;
                $display("FAIL %s outputs: got x=%0d y=%0d left=%b anim=%0d mov=%b, expected x=%0d y=%0d left=%b anim=%0d mov=%b",
                         name, playerX, playerY, left, anim_frame, moving,
                         e.x, e.y, e.left, e.anim, e.moving);
            end
            @(posedge Clk); #1;
            n_cmp++;
            if (update_done !== 1'b0) begin
                n_err++;
                $display("FAIL %s strobe width: update_done=%b one edge later, expected 0", name, update_done);
            end
        end
    endtask

    task automatic test_reset();
        int pulses;
        apply_reset();
        n_cmp++;
        if (playerX !== 10'd32 || playerY !== 10'd32 || left !== 1'b0 ||
            anim_frame !== 2'd0 || moving !== 1'b0 || update_done !== 1'b0) begin
            n_err++;
            $display("FAIL reset values: got x=%0d y=%0d left=%b anim=%0d mov=%b done=%b, expected 32 32 0 0 0 0",
                     playerX, playerY, left, anim_frame, moving, update_done);
        end
        pulses = 0;
        repeat (12) begin @(posedge Clk); #1; if (update_done) pulses++; end
        n_cmp++;
        if (pulses != 0) begin
            n_err++;
            $display("FAIL reset idle strobe: got %0d pulses, expected 0", pulses);
        end
    endtask

    task automatic test_move_right();
        apply_reset();
        do_update(8'h07, "move_right");
        n_cmp++;
        if (playerX !== 10'd34 || playerY !== 10'd32 || moving !== 1'b1) begin
            n_err++;
            $display("FAIL move_right abs: got x=%0d y=%0d mov=%b, expected 34 32 1", playerX, playerY, moving);
        end
        do_update(8'h1A, "move_up");
        do_update(8'h16, "move_down");
        do_update(8'h04, "move_left");
    endtask

    task automatic test_wall();
        logic [4:0] vals [4];
        vals[0] = 5'd1; vals[1] = 5'd5; vals[2] = 5'd6; vals[3] = 5'd2;
        for (int i = 0; i < 4; i++) begin
            apply_reset();
            set_tile(2, 3, vals[i]);
            do_update(8'h07, "wall_first");
            do_update(8'h07, "wall_second");
            n_cmp++;
            if (playerX !== ((vals[i] == 5'd2) ? 10'd36 : 10'd34) || left !== 1'b0) begin
                n_err++;
                $display("FAIL wall tile=%0d: got x=%0d left=%b", vals[i], playerX, left);
            end
            set_tile(2, 3, 5'd0);
        end
    endtask

    task automatic test_clamp();
        apply_reset();
        for (int i = 0; i < 17; i++) do_update(8'h04, "clamp_left");
        n_cmp++;
        if (playerX !== 10'd0 || left !== 1'b1) begin
            n_err++;
            $display("FAIL clamp_left abs: got x=%0d left=%b, expected 0 1", playerX, left);
        end
        for (int i = 0; i < 137; i++) do_update(8'h16, "clamp_down");
        n_cmp++;
        if (playerY !== 10'd303) begin
            n_err++;
            $display("FAIL clamp_down abs: got y=%0d, expected 303", playerY);
        end
        do_update(8'h1A, "after_clamp_up");
    endtask

    task automatic test_animation();
        apply_reset();
        for (int i = 0; i < 8; i++) do_update(8'h00, "anim");
        n_cmp++;
        if (anim_frame !== 2'd1 || moving !== 1'b0) begin
            n_err++;
            $display("FAIL anim abs: got anim=%0d mov=%b, expected 1 0", anim_frame, moving);
        end
        for (int i = 0; i < 24; i++) do_update(8'h00, "anim_wrap");
    endtask

    // First tick at edge k, second tick sampled at edge k+gap.
    task automatic test_back_to_back(input int gap, input string name);
        exp_t e;
        int pulses, first, second;
        bool_accept: begin end
        pulses = 0; first = -1; second = -1;
        @(negedge Clk);
        keycode = 8'h07;
        frame_clk = 1'b1;
        sb.push_back(model_step(8'h07));
        @(posedge Clk);
        for (int ed = 1; ed <= 26; ed++) begin
            @(negedge Clk);
            frame_clk = (ed == gap);
            if (ed == gap && gap >= 8) sb.push_back(model_step(8'h07));
            @(posedge Clk); #1;
            if (update_done) begin
                pulses++;
                if (first < 0) first = ed; else second = ed;
                n_cmp++;
                if (sb.size() == 0) begin
                    n_err++;
                    $display("FAIL %s: unexpected update_done at edge %0d", name, ed);
                end else begin
                    e = sb.pop_front();
                    if (playerX !== e.x || playerY !== e.y || anim_frame !== e.anim) begin
                        n_err++;
                        $display("FAIL %s outputs: got x=%0d y=%0d anim=%0d, expected %0d %0d %0d",
                                 name, playerX, playerY, anim_frame, e.x, e.y, e.anim);
                    end
                end
            end
        end
        frame_clk = 1'b0;
        n_cmp++;
        if (pulses != ((gap >= 8) ? 2 : 1) || first != 7 || (gap >= 8 && second != gap + 7)) begin
            n_err++;
            $display("FAIL %s pulses: got count=%0d first=%0d second=%0d (gap %0d)", name, pulses, first, second, gap);
        end
        sb.delete();
    endtask

    task automatic test_reset_mid();
        int pulses;
        apply_reset();
        @(negedge Clk);
        keycode = 8'h07;
        frame_clk = 1'b1;
        @(posedge Clk);
        @(negedge Clk);
        frame_clk = 1'b0;
        repeat (3) @(posedge Clk);
        @(negedge Clk);
        reset = 1'b1;
        @(negedge Clk);
        reset = 1'b0;
        model_reset();
        pulses = 0;
        repeat (12) begin @(posedge Clk); #1; if (update_done) pulses++; end
        n_cmp++;
        if (pulses != 0 || playerX !== 10'd32 || playerY !== 10'd32 || left !== 1'b0 ||
            anim_frame !== 2'd0 || moving !== 1'b0) begin
            n_err++;
            $display("FAIL reset_mid: got pulses=%0d x=%0d y=%0d left=%b anim=%0d mov=%b, expected 0 32 32 0 0 0",
                     pulses, playerX, playerY, left, anim_frame, moving);
        end
        do_update(8'h07, "after_reset_mid");
    endtask

    initial begin
        for (int r = 0; r < 20; r++)
            for (int c = 0; c < 20; c++)
                tmap[r][c] = 5'd0;
        model_reset();
        test_reset();
        test_move_right();
        test_wall();
        test_clamp();
        test_animation();
        apply_reset();
        test_back_to_back(3, "dropped_tick");
        test_back_to_back(7, "busy_edge");
        test_back_to_back(8, "back_to_back");
        test_reset_mid();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
